nmi_arb2: RTL and testbench

NMI_ARB2 -- requirements
Module: nmi_arb2

---
 rtl/nmi_arb2.sv | 114 +++++++++++
 tb/tb_nmi_arb2.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/nmi_arb2.sv
// Two-master round-robin arbiter in front of a single NMI slave, with a
// per-transaction timeout that completes the master with an error word.
//
// state | meaning
// IDLE  | no slave cycle in flight; pick a master (round-robin on ties)
// BUSY  | slave cycle for master gnt in flight; waiting for s_ready_i or timeout
module nmi_arb2 #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        m0_valid_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_wstrb_i,
  output logic        m0_ready_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_valid_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_wstrb_i,
  output logic        m1_ready_o,
  output logic [31:0] m1_rdata_o,
  output logic        s_valid_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic [3:0]  s_wstrb_o,
  input  logic        s_ready_i,
  input  logic [31:0] s_rdata_i,
  output logic        timeout_o,
  output logic [7:0]  timeout_cnt_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Down-counter loaded on grant; reaching zero marks the TIMEOUT-th BUSY cycle.
  localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic [15:0] tmr_q, tmr_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        done;
  logic        tout;
  logic [31:0] cpl_data;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      tmr_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      tmr_q   <= tmr_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    tmr_d    = tmr_q;
    tcnt_d   = tcnt_q;
    done     = 1'b0;
    tout     = 1'b0;
    cpl_data = s_rdata_i;
    unique case (state_q)
      IDLE: begin
        if (m0_valid_i || m1_valid_i) begin
          if (m0_valid_i && m1_valid_i) gnt_d = ~last_q;
          else                          gnt_d = m1_valid_i;
          last_d  = gnt_d;
          tmr_d   = TMR_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A slave completion in the terminal cycle beats the timeout.
        if (s_ready_i) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (tmr_q == '0) begin
          done     = 1'b1;
          tout     = 1'b1;
          cpl_data = ERR_DATA;
          state_d  = IDLE;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_valid_o     = (state_q == BUSY);
  assign s_addr_o      = gnt_q ? m1_addr_i  : m0_addr_i;
  assign s_wdata_o     = gnt_q ? m1_wdata_i : m0_wdata_i;
  assign s_wstrb_o     = gnt_q ? m1_wstrb_i : m0_wstrb_i;
  assign m0_ready_o    = done & ~gnt_q;
  assign m1_ready_o    = done & gnt_q;
  assign m0_rdata_o    = m0_ready_o ? cpl_data : 32'h0;
  assign m1_rdata_o    = m1_ready_o ? cpl_data : 32'h0;
  assign timeout_o     = tout;
  assign timeout_cnt_o = tcnt_q;

endmodule

// File: tb/tb_nmi_arb2.sv
// Directed bench for nmi_arb2: stimulus pushes expected completions into a
// scoreboard queue, a negedge monitor pops and checks each master completion.
module tb_nmi_arb2;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        m0_valid_i = 1'b0, m1_valid_i = 1'b0;
  logic [31:0] m0_addr_i = '0, m0_wdata_i = '0, m1_addr_i = '0, m1_wdata_i = '0;
  logic [3:0]  m0_wstrb_i = '0, m1_wstrb_i = '0;
  logic        m0_ready_o, m1_ready_o, s_valid_o, timeout_o, s_ready_i;
  logic [31:0] m0_rdata_o, m1_rdata_o, s_addr_o, s_wdata_o;
  logic [3:0]  s_wstrb_o;
  logic [31:0] s_rdata_i = '0;
  logic [7:0]  timeout_cnt_o;

  nmi_arb2 #(.TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m0_valid_i(m0_valid_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_wstrb_i(m0_wstrb_i), .m0_ready_o(m0_ready_o), .m0_rdata_o(m0_rdata_o),
    .m1_valid_i(m1_valid_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_wstrb_i(m1_wstrb_i), .m1_ready_o(m1_ready_o), .m1_rdata_o(m1_rdata_o),
    .s_valid_o(s_valid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_wstrb_o(s_wstrb_o), .s_ready_i(s_ready_i), .s_rdata_i(s_rdata_i),
    .timeout_o(timeout_o), .timeout_cnt_o(timeout_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        id;
    logic [31:0] rdata;
    logic        to;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic push(input logic id, input logic [31:0] rdata, input logic to, input int lat);
    exp_t e;
    e.id = id; e.rdata = rdata; e.to = to; e.lat = lat;
    sb_q.push_back(e);
  endtask

  // Slave model: readies in BUSY cycle slave_lat (0 = never).
  int busy_cnt = 0;
  int slave_lat = 1;
  initial begin
    s_ready_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      if (s_valid_o) begin
        busy_cnt++;
        s_ready_i = (slave_lat != 0) && (busy_cnt == slave_lat);
      end else begin
        busy_cnt  = 0;
        s_ready_i = 1'b0;
      end
    end
  end

  int run_len = 0, last_len = 0;
  logic        pt_en = 1'b0;
  logic [31:0] pt_addr, pt_wdata;
  logic [3:0]  pt_wstrb;

  // Scoreboard monitor plus s_valid_o run length and pass-through sampling.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (s_valid_o) run_len++;
      else if (run_len != 0) begin last_len = run_len; run_len = 0; end
      if (pt_en && s_valid_o) begin
        chk("pt_addr", s_addr_o, pt_addr);
        chk("pt_wdata", s_wdata_o, pt_wdata);
        chk("pt_wstrb", {28'h0, s_wstrb_o}, {28'h0, pt_wstrb});
      end
      if (!m0_ready_o && m0_rdata_o !== 32'h0) chk("m0_rdata_idle", m0_rdata_o, 32'h0);
      if (!m1_ready_o && m1_rdata_o !== 32'h0) chk("m1_rdata_idle", m1_rdata_o, 32'h0);
      if (m0_ready_o || m1_ready_o) begin
        if (m0_ready_o && m1_ready_o) chk("both_ready", 32'd1, 32'd0);
        if (sb_q.size() == 0) chk("unexpected_ready", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          chk("sb_master", {31'h0, m1_ready_o}, {31'h0, e.id});
          chk("sb_rdata", m1_ready_o ? m1_rdata_o : m0_rdata_o, e.rdata);
          chk("sb_timeout", {31'h0, timeout_o}, {31'h0, e.to});
          chk("sb_busy_cycle", busy_cnt, e.lat);
        end
      end else if (timeout_o) begin
        chk("stray_timeout", 32'd1, 32'd0);
      end
    end
  end

  // Raises valid now, holds until ready (bounded), drops it just after the edge.
  task automatic m_xfer(input logic id, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb);
    bit got = 0;
    if (!id) begin m0_valid_i = 1; m0_addr_i = addr; m0_wdata_i = wdata; m0_wstrb_i = wstrb; end
    else     begin m1_valid_i = 1; m1_addr_i = addr; m1_wdata_i = wdata; m1_wstrb_i = wstrb; end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk_i);
      got = id ? m1_ready_o : m0_ready_o;
    end
    if (!got) chk("xfer_wait", 32'd0, 32'd1);
    @(posedge clk_i); #1;
    if (!id) m0_valid_i = 0; else m1_valid_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vpat;
    bit seen;
    #12;
    chk("rst_s_valid", {31'h0, s_valid_o}, 32'd0);
    chk("rst_m0_ready", {31'h0, m0_ready_o}, 32'd0);
    chk("rst_m1_ready", {31'h0, m1_ready_o}, 32'd0);
    chk("rst_timeout", {31'h0, timeout_o}, 32'd0);
    chk("rst_tcnt", {24'h0, timeout_cnt_o}, 32'd0);
    @(posedge clk_i); #1 rst_n_i = 1;

    // Tie after reset: alternating m0, m1, m0, m1 with one IDLE between grants.
    slave_lat = 1; s_rdata_i = 32'h0000_1111;
    push(0, 32'h0000_1111, 0, 1); push(1, 32'h0000_1111, 0, 1);
    push(0, 32'h0000_1111, 0, 1); push(1, 32'h0000_1111, 0, 1);
    @(posedge clk_i); #1;
    fork
      begin m_xfer(0, 32'h100, 0, 0); m_xfer(0, 32'h104, 0, 0); end
      begin m_xfer(1, 32'h200, 0, 0); m_xfer(1, 32'h204, 0, 0); end
      for (int i = 0; i < 8; i++) begin
        @(negedge clk_i); vpat = {vpat[6:0], s_valid_o};
      end
    join
    chk("tie_valid_pattern", {24'h0, vpat}, 32'h55);

    // Single read, slave ready in the 3rd BUSY cycle.
    slave_lat = 3; s_rdata_i = 32'h1234_5678;
    push(0, 32'h1234_5678, 0, 3);
    @(posedge clk_i); #1;
    m_xfer(0, 32'h0000_1000, 0, 4'b0000);
    @(negedge clk_i); @(negedge clk_i);
    chk("read_valid_len", last_len, 32'd3);
    chk("read_sb_drained", sb_q.size(), 32'd0);

    // Write pass-through from m1.
    slave_lat = 2; s_rdata_i = 32'h0BAD_F00D;
    pt_addr = 32'h0000_2004; pt_wdata = 32'hA5A5_A5A5; pt_wstrb = 4'b0011; pt_en = 1;
    push(1, 32'h0BAD_F00D, 0, 2);
    @(posedge clk_i); #1;
    m_xfer(1, 32'h0000_2004, 32'hA5A5_A5A5, 4'b0011);
    pt_en = 0;

    // Timeout: slave never readies.
    slave_lat = 0;
    push(0, 32'hDEAD_BEEF, 1, 4);
    @(posedge clk_i); #1;
    m_xfer(0, 32'h3000, 0, 0);
    chk("tcnt_after_1", {24'h0, timeout_cnt_o}, 32'd1);

    // Coincidence: ready lands exactly in the timeout cycle.
    slave_lat = 4; s_rdata_i = 32'h7777_0001;
    push(1, 32'h7777_0001, 0, 4);
    @(posedge clk_i); #1;
    m_xfer(1, 32'h3004, 0, 0);
    chk("tcnt_coincide", {24'h0, timeout_cnt_o}, 32'd1);

    // 299 more timeouts: 300 total saturates at 255.
    slave_lat = 0;
    for (int i = 0; i < 299; i++) begin
      push(0, 32'hDEAD_BEEF, 1, 4);
      @(posedge clk_i); #1;
      m_xfer(0, 32'h4000, 0, 0);
      if (i == 5) chk("tcnt_after_7", {24'h0, timeout_cnt_o}, 32'd7);
    end
    chk("tcnt_saturated", {24'h0, timeout_cnt_o}, 32'd255);

    // Reset two cycles into a grant.
    slave_lat = 0;
    @(posedge clk_i); #1 m0_valid_i = 1; m0_addr_i = 32'h5000;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk_i); seen = s_valid_o; end
    chk("rmb_grant_seen", {31'h0, seen}, 32'd1);
    @(negedge clk_i);
    #2 rst_n_i = 0;
    #1;
    chk("rmb_s_valid_async", {31'h0, s_valid_o}, 32'd0);
    chk("rmb_m0_ready", {31'h0, m0_ready_o}, 32'd0);
    chk("rmb_m1_ready", {31'h0, m1_ready_o}, 32'd0);
    m0_valid_i = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1;
    chk("rmb_tcnt_cleared", {24'h0, timeout_cnt_o}, 32'd0);

    slave_lat = 1; s_rdata_i = 32'h0000_2222;
    push(0, 32'h0000_2222, 0, 1); push(1, 32'h0000_2222, 0, 1);
    @(posedge clk_i); #1;
    fork
      m_xfer(0, 32'h6000, 0, 0);
      m_xfer(1, 32'h6004, 0, 0);
    join

    repeat (3) @(negedge clk_i);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
